// File: rtl/add_pipe_pkg.sv
// Shared constants, parameter checks and stage-control typedef for add_pipe.
package add_pipe_pkg;

  localparam int MIN_WIDTH  = 1;
  localparam int MIN_STAGES = 1;

  // Control part of each stage register; data fields are sized per stage in the top.
  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctl_t;

  function automatic bit params_ok(input int width, input int stages);
    return (width >= MIN_WIDTH) && (stages >= MIN_STAGES) &&
           (stages <= width) && ((width % stages) == 0);
  endfunction

  function automatic int slice_width(input int width, input int stages);
    return (stages > 0) ? (width / stages) : 1;
  endfunction

endpackage

// File: rtl/add_pipe_slice.sv
// Combinational SLICE-bit ripple adder built from full-adder cells.
module add_pipe_slice
  import add_pipe_pkg::*;
#(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             ci,
  output logic [SLICE-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [SLICE:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < SLICE; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co    = c[SLICE];
  assign c_msb = c[SLICE-1];

endmodule

// File: rtl/add_pipe.sv
// Pipelined ripple-carry adder with valid/ready handshake, one slice per stage.
// Define ADD_PIPE_SUB_EN to honour op_sub (A-B); otherwise the block is add only.
module add_pipe
  import add_pipe_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int SLICE = slice_width(WIDTH, STAGES);

  if (!params_ok(WIDTH, STAGES)) begin : g_param_check
    $error("add_pipe: WIDTH must be >= 1, 1 <= STAGES <= WIDTH and WIDTH %% STAGES == 0");
  end

  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

`ifdef ADD_PIPE_SUB_EN
  // Subtraction is A + ~B + 1, so the inversion happens once at capture.
  assign b_eff   = op_sub ? ~b : b;
  assign cin_eff = op_sub ? 1'b1 : cin;
`else
  logic unused_op_sub;
  assign unused_op_sub = op_sub;
  assign b_eff         = b;
  assign cin_eff       = cin;
`endif

  logic [STAGES:0] ready;

  assign ready[STAGES] = out_ready;
  assign in_ready      = ready[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SLICE;
    localparam int PW = (k + 1) * SLICE;

    logic [WIDTH-LO-1:0] ain;
    logic [WIDTH-LO-1:0] bin;
    logic                ci;
    logic                vin;
    logic [PW-1:0]       psum_d;
    logic [PW-1:0]       psum_q;
    logic [SLICE-1:0]    s;
    logic                co;
    logic                c_msb;
    logic                load;
    stage_ctl_t          ctl_q;

    if (k == 0) begin : g_src
      assign ain    = a;
      assign bin    = b_eff;
      assign ci     = cin_eff;
      assign vin    = in_valid;
      assign psum_d = s;
    end else begin : g_src
      assign ain    = g_stage[k-1].g_rem.rem_a_q;
      assign bin    = g_stage[k-1].g_rem.rem_b_q;
      assign ci     = g_stage[k-1].ctl_q.carry;
      assign vin    = g_stage[k-1].ctl_q.valid;
      assign psum_d = {s, g_stage[k-1].psum_q};
    end

    // A bubble in this stage lets it load even when downstream is stalled.
    assign ready[k] = !ctl_q.valid || ready[k+1];
    assign load     = ready[k] && vin;

    add_pipe_slice #(.SLICE(SLICE)) u_slice (
      .a    (ain[SLICE-1:0]),
      .b    (bin[SLICE-1:0]),
      .ci   (ci),
      .s    (s),
      .co   (co),
      .c_msb(c_msb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ctl_q  <= '0;
        psum_q <= '0;
      end else begin
        if (ready[k]) ctl_q.valid <= vin;
        if (load) begin
          ctl_q.carry <= co;
          psum_q      <= psum_d;
        end
      end
    end

    if (k < STAGES - 1) begin : g_rem
      logic [WIDTH-PW-1:0] rem_a_q;
      logic [WIDTH-PW-1:0] rem_b_q;
      logic                unused_c_msb;

      assign unused_c_msb = c_msb;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rem_a_q <= '0;
          rem_b_q <= '0;
        end else if (load) begin
          rem_a_q <= ain[WIDTH-LO-1:SLICE];
          rem_b_q <= bin[WIDTH-LO-1:SLICE];
        end
      end
    end else begin : g_last
      logic c_msb_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) c_msb_q <= 1'b0;
        else if (load) c_msb_q <= c_msb;
      end

      assign out_valid = ctl_q.valid;
      assign sum       = psum_q;
      assign carry     = ctl_q.carry;
      assign overflow  = ctl_q.carry ^ c_msb_q;
    end
  end

endmodule
